// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tetris (package)
// Description : Shared types and constants for the playfield matrix memory:
//               block origin point, 4x4 shape bitmap, controller state
//               encoding and the maximum number of rows one drop can clear.
// Revision    : 1.0 - initial release
// ============================================================================
package tetris;

    // Block origin on the playfield: x is the column, y is the row (0 = top).
    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } point_t;

    // Shape bitmap: bit [r][c] lands on playfield cell (y+r, x+c).
    typedef logic [3:0][3:0] shape_t;

    // Controller states, explicit 3-bit encoding.
    typedef enum logic [2:0] {
        eIDLE  = 3'd0,
        eMerge = 3'd1,
        eScan  = 3'd2,
        eFill  = 3'd3,
        eDone  = 3'd4
    } state_e;

    // A 4-row shape can complete at most four rows in a single drop.
    localparam int max_lines_c = 4;

endpackage : tetris
`default_nettype wire

// File: rtl/matrix_line_clear.sv
`default_nettype none
// ============================================================================
// Module      : matrix_line_clear
// Description : Row compaction engine. During scan it walks a source and a
//               destination pointer from the bottom row upwards, skipping
//               full rows and copying every other row down to dst. During
//               fill it zeroes the rows left vacant at the top.
// Revision    : 1.0 - initial release
// Ports       : clk_i/reset_i  clock, async active-low reset
//               init_i         reload pointers and count (held during merge)
//               scan_i/fill_i  current phase of the owning controller
//               src_row_i      matrix row currently addressed by src_o
//               src_o/dst_o    read / write row pointers
//               wr_v_o         write dst_o with wr_data_o this cycle
//               scan_last_o    this is the final scan cycle
//               fill_last_o    this is the final fill cycle
//               count_nxt_o    cleared-row count including this cycle
// ============================================================================
module matrix_line_clear
    import tetris::*;
#(
    parameter int width_p  = 16,
    parameter int height_p = 32
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              init_i,
    input  logic                              scan_i,
    input  logic                              fill_i,
    input  logic [width_p-1:0]                src_row_i,
    output logic [$clog2(height_p)-1:0]       src_o,
    output logic [$clog2(height_p)-1:0]       dst_o,
    output logic                              wr_v_o,
    output logic [width_p-1:0]                wr_data_o,
    output logic                              scan_last_o,
    output logic                              fill_last_o,
    output logic [$clog2(max_lines_c+1)-1:0]  count_nxt_o
);

    localparam int c_aw = $clog2(height_p);
    localparam int c_cw = $clog2(max_lines_c + 1);

    logic [c_aw-1:0] r_src;
    logic [c_aw-1:0] r_dst;
    logic [c_cw-1:0] r_count;
    logic            w_full;

    assign w_full      = &src_row_i;
    assign count_nxt_o = r_count + c_cw'(scan_i && w_full);

    // A full row is simply not copied; fill writes zeros at dst.
    assign wr_v_o      = (scan_i && !w_full) || fill_i;
    assign wr_data_o   = fill_i ? '0 : src_row_i;

    // src decrements every scan cycle from height_p-1, so it reaching 0 marks
    // the last of height_p scan cycles. After scan, dst = count-1, so fill
    // ends when dst reaches row 0.
    assign scan_last_o = (r_src == '0);
    assign fill_last_o = (r_dst == '0);

    assign src_o = r_src;
    assign dst_o = r_dst;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_count <= '0;
        end else if (init_i) begin
            r_src   <= c_aw'(height_p - 1);
            r_dst   <= c_aw'(height_p - 1);
            r_count <= '0;
        end else if (scan_i) begin
            r_src   <= r_src - 1'b1;
            r_count <= count_nxt_o;
            if (!w_full) begin
                r_dst <= r_dst - 1'b1;
            end
        end else if (fill_i) begin
            r_dst <= r_dst - 1'b1;
        end
    end

endmodule : matrix_line_clear
`default_nettype wire

// File: rtl/matrix_memory.sv
`default_nettype none
// ============================================================================
// Module      : matrix_memory
// Description : Playfield occupancy matrix. A write ORs a 4x4 shape into the
//               matrix one row per cycle, clipping cells outside the field.
//               With MATRIX_LINE_CLEAR_EN defined, full rows are then removed
//               and the rows above shifted down; the number of cleared rows
//               is reported with a one-cycle completion pulse.
// Revision    : 1.0 - initial release
// Macro       : MATRIX_LINE_CLEAR_EN - enables row clearing (scan/fill)
// Ports       : clk_i            clock
//               reset_i          async active-low reset
//               mm_write_addr_i  shape origin (x column, y row)
//               mm_write_data_i  shape bitmap
//               mm_write_v_i     write request
//               mm_is_ready_o    idle, write will be accepted
//               rd_row_addr_i    read row select
//               rd_row_data_o    registered row contents (1-cycle latency)
//               lines_v_o        end-of-operation pulse
//               lines_o          rows cleared by the last operation
// ============================================================================
module matrix_memory
    import tetris::*;
#(
    parameter int width_p  = 16,
    parameter int height_p = 32
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  point_t                      mm_write_addr_i,
    input  shape_t                      mm_write_data_i,
    input  logic                        mm_write_v_i,
    output logic                        mm_is_ready_o,
    input  logic [$clog2(height_p)-1:0] rd_row_addr_i,
    output logic [width_p-1:0]          rd_row_data_o,
    output logic                        lines_v_o,
    output logic [2:0]                  lines_o
);

    localparam int c_aw = $clog2(height_p);

    state_e             r_state;
    state_e             w_state_nxt;
    logic               r_ready;
    logic [1:0]         r_merge_cnt;
    point_t             r_origin;
    shape_t             r_shape;
    logic [width_p-1:0] r_rows [height_p];
    logic [width_p-1:0] r_rd;

    logic               w_accept;
    logic [width_p+3:0] w_ext;
    logic [width_p-1:0] w_merge_bits;
    logic [8:0]         w_row_sum;
    logic               w_row_ok;
    logic [c_aw-1:0]    w_row_idx;

    assign w_accept = (r_state == eIDLE) && r_ready && mm_write_v_i;

    // Shape row placed at column x; bits shifted past width_p fall off the
    // top of the extended vector, so there is no wrap into low columns.
    assign w_ext        = {{width_p{1'b0}}, r_shape[r_merge_cnt]} << r_origin.x;
    assign w_merge_bits = w_ext[width_p-1:0];
    assign w_row_sum    = {1'b0, r_origin.y} + {7'd0, r_merge_cnt};
    assign w_row_ok     = (w_row_sum < 9'(height_p));
    assign w_row_idx    = w_row_sum[c_aw-1:0];

`ifdef MATRIX_LINE_CLEAR_EN
    logic [c_aw-1:0]    w_lc_src;
    logic [c_aw-1:0]    w_lc_dst;
    logic               w_lc_wr_v;
    logic [width_p-1:0] w_lc_wr_data;
    logic               w_scan_last;
    logic               w_fill_last;
    logic [2:0]         w_count_nxt;
    logic [2:0]         r_lines;

    matrix_line_clear #(
        .width_p  (width_p),
        .height_p (height_p)
    ) u_line_clear (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .init_i      (r_state == eMerge),
        .scan_i      (r_state == eScan),
        .fill_i      (r_state == eFill),
        .src_row_i   (r_rows[w_lc_src]),
        .src_o       (w_lc_src),
        .dst_o       (w_lc_dst),
        .wr_v_o      (w_lc_wr_v),
        .wr_data_o   (w_lc_wr_data),
        .scan_last_o (w_scan_last),
        .fill_last_o (w_fill_last),
        .count_nxt_o (w_count_nxt)
    );

    // Captured on entry to eDone and held until the next operation ends.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_lines <= '0;
        end else if ((w_state_nxt == eDone) && (r_state != eDone)) begin
            r_lines <= w_count_nxt;
        end
    end

    assign lines_o = r_lines;
`else
    assign lines_o = '0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            eIDLE: begin
                if (w_accept) w_state_nxt = eMerge;
            end
            eMerge: begin
`ifdef MATRIX_LINE_CLEAR_EN
                if (r_merge_cnt == 2'd3) w_state_nxt = eScan;
`else
                if (r_merge_cnt == 2'd3) w_state_nxt = eDone;
`endif
            end
`ifdef MATRIX_LINE_CLEAR_EN
            eScan: begin
                if (w_scan_last) w_state_nxt = (w_count_nxt != '0) ? eFill : eDone;
            end
            eFill: begin
                if (w_fill_last) w_state_nxt = eDone;
            end
`endif
            eDone:   w_state_nxt = eIDLE;
            default: w_state_nxt = eIDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state     <= eIDLE;
            r_ready     <= 1'b0;
            r_merge_cnt <= '0;
            r_origin    <= '0;
            r_shape     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ready     <= (w_state_nxt == eIDLE);
            r_merge_cnt <= (r_state == eMerge) ? r_merge_cnt + 2'd1 : 2'd0;
            if (w_accept) begin
                r_origin <= mm_write_addr_i;
                r_shape  <= mm_write_data_i;
            end
        end
    end

    // Matrix storage: merge ORs a shape row in; compaction overwrites rows.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < height_p; i++) begin
                r_rows[i] <= '0;
            end
        end else begin
            if ((r_state == eMerge) && w_row_ok) begin
                r_rows[w_row_idx] <= r_rows[w_row_idx] | w_merge_bits;
            end
`ifdef MATRIX_LINE_CLEAR_EN
            else if (w_lc_wr_v) begin
                r_rows[w_lc_dst] <= w_lc_wr_data;
            end
`endif
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_rd <= '0;
        end else begin
            r_rd <= r_rows[rd_row_addr_i];
        end
    end

    assign rd_row_data_o = r_rd;
    assign mm_is_ready_o = r_ready;
    assign lines_v_o     = (r_state == eDone);

endmodule : matrix_memory
`default_nettype wire

// File: tb/tb_matrix_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_memory
// Description : Self-checking bench for matrix_memory. A reference playfield
//               kept as a plain array is updated per write (clip, OR, then
//               remove full rows when line clearing is built in) and the DUT
//               is compared against it for rows, latency, counts and status.
// Revision    : 1.0 - initial release
// Macro       : MATRIX_LINE_CLEAR_EN - selects expected clearing behaviour
// ============================================================================
module tb_matrix_memory;
    import tetris::*;

    localparam int W = 16;
    localparam int H = 32;
`ifdef MATRIX_LINE_CLEAR_EN
    localparam bit c_clear_en = 1'b1;
`else
    localparam bit c_clear_en = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         reset_i;
    point_t       wr_addr;
    shape_t       wr_data;
    logic         wr_v;
    logic         ready;
    logic [4:0]   rd_addr;
    logic [W-1:0] rd_data;
    logic         lines_v;
    logic [2:0]   lines;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] model [H];

    always #5 clk_i = ~clk_i;

    matrix_memory #(
        .width_p  (W),
        .height_p (H)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .mm_write_addr_i (wr_addr),
        .mm_write_data_i (wr_data),
        .mm_write_v_i    (wr_v),
        .mm_is_ready_o   (ready),
        .rd_row_addr_i   (rd_addr),
        .rd_row_data_o   (rd_data),
        .lines_v_o       (lines_v),
        .lines_o         (lines)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: place the shape with clipping, then drop every full row and
    // let the remaining rows settle to the bottom in order.
    function automatic int model_write(input int x, input int y, input logic [15:0] shp);
        logic [W-1:0] nxt [H];
        int wr;
        int cnt;
        cnt = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (shp[r*4+c] && (x + c < W) && (y + r < H))
                    model[y+r][x+c] = 1'b1;
        if (c_clear_en) begin
            wr = H - 1;
            for (int r = H - 1; r >= 0; r--) begin
                if (model[r] == {W{1'b1}}) cnt++;
                else begin
                    nxt[wr] = model[r];
                    wr--;
                end
            end
            for (int r = wr; r >= 0; r--) nxt[r] = '0;
            for (int r = 0; r < H; r++) model[r] = nxt[r];
        end
        return cnt;
    endfunction

    task automatic check_rows(input string tag);
        for (int r = 0; r < H; r++) begin
            @(negedge clk_i);
            rd_addr = 5'(r);
            @(negedge clk_i);
            check_eq($sformatf("%s_row%0d", tag, r), 32'(rd_data), 32'(model[r]));
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b0;
        wr_v    = 1'b0;
        for (int r = 0; r < H; r++) model[r] = '0;
        repeat (2) begin
            @(negedge clk_i);
            check_eq("rst_ready", 32'(ready), 0);
            check_eq("rst_rd_data", 32'(rd_data), 0);
            check_eq("rst_lines_v", 32'(lines_v), 0);
            check_eq("rst_lines", 32'(lines), 0);
        end
        reset_i = 1'b1;
        #1;
        check_eq("ready_before_first_edge", 32'(ready), 0);
        @(negedge clk_i);
        check_eq("ready_after_release", 32'(ready), 1);
    endtask

    // One write: hold request for 'hold' cycles (clipped so it cannot start
    // a second operation), then track status until the completion pulse.
    task automatic run_op(input int x, input int y, input logic [15:0] shp, input int hold);
        int exp_cnt;
        int exp_lat;
        int hold_eff;
        int seen_k;
        @(negedge clk_i);
        check_eq("ready_before_write", 32'(ready), 1);
        wr_addr.x = 8'(x);
        wr_addr.y = 8'(y);
        wr_data   = shp;
        wr_v      = 1'b1;
        @(posedge clk_i);
        exp_cnt  = model_write(x, y, shp);
        exp_lat  = c_clear_en ? (4 + H + exp_cnt + 1) : 5;
        hold_eff = (hold < exp_lat) ? hold : exp_lat - 1;
        seen_k   = 0;
        for (int k = 1; k <= 200 && seen_k == 0; k++) begin
            @(negedge clk_i);
            if (k >= hold_eff) wr_v = 1'b0;
            if (lines_v) begin
                seen_k = k;
                check_eq("latency", 32'(k), 32'(exp_lat));
                check_eq("lines_at_done", 32'(lines), 32'(exp_cnt));
                check_eq("ready_in_done", 32'(ready), 0);
            end else begin
                check_eq("ready_while_busy", 32'(ready), 0);
            end
        end
        if (seen_k == 0) check_eq("lines_v_timeout", 0, 1);
        wr_v = 1'b0;
        @(negedge clk_i);
        check_eq("ready_after_done", 32'(ready), 1);
        check_eq("lines_v_single", 32'(lines_v), 0);
        check_eq("lines_held", 32'(lines), 32'(exp_cnt));
        @(negedge clk_i);
        check_eq("no_second_accept", 32'(ready), 1);
    endtask

    initial begin
        reset_i = 1'b0;
        wr_v    = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;

        // Single cell at the top-left corner.
        do_reset();
        run_op(0, 0, 16'h0001, 1);
        check_rows("single_cell");

        // Bottom row one short of full, row 30 partly filled, then complete it.
        do_reset();
        run_op(0, 28, 16'hF000, 1);
        run_op(4, 28, 16'hF000, 1);
        run_op(8, 28, 16'hF000, 1);
        run_op(12, 28, 16'h7000, 1);
        run_op(0, 27, 16'h5000, 1);
        check_rows("preset_bottom");
        run_op(12, 28, 16'h8000, 1);
        check_rows("clear_one");

        // Four rows one short, completed by a vertical I-piece.
        do_reset();
        run_op(0, 28, 16'hFFFF, 1);
        run_op(4, 28, 16'hFFFF, 1);
        run_op(8, 28, 16'hFFFF, 1);
        run_op(12, 28, 16'h7777, 1);
        run_op(15, 28, 16'h1111, 1);
        check_rows("clear_four");

        // Clipping at the bottom-right corner.
        do_reset();
        run_op(14, 30, 16'hFFFF, 1);
        check_rows("clip_corner");

        // Request held high across the busy period.
        run_op(0, 0, 16'h0003, 10);
        check_rows("held_request");

        // Reset in the middle of an operation.
        @(negedge clk_i);
        check_eq("ready_before_abort", 32'(ready), 1);
        wr_addr.x = 8'd0;
        wr_addr.y = 8'd20;
        wr_data   = 16'h0F0F;
        wr_v      = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        wr_v = 1'b0;
        repeat (c_clear_en ? 9 : 1) @(negedge clk_i);
        reset_i = 1'b0;
        for (int r = 0; r < H; r++) model[r] = '0;
        #1;
        check_eq("abort_lines_v", 32'(lines_v), 0);
        check_eq("abort_ready", 32'(ready), 0);
        repeat (3) begin
            @(negedge clk_i);
            check_eq("abort_hold_lines_v", 32'(lines_v), 0);
        end
        reset_i = 1'b1;
        @(negedge clk_i);
        check_eq("abort_ready_after_release", 32'(ready), 1);
        check_eq("abort_lines", 32'(lines), 0);
        check_eq("abort_no_pulse", 32'(lines_v), 0);
        check_rows("after_abort");

        // Randomised drops near the bottom, biased towards completing rows.
        for (int i = 0; i < 10; i++) begin
            int rx;
            int ry;
            logic [15:0] rs;
            rx = int'($urandom_range(0, 17));
            ry = int'($urandom_range(26, 31));
            rs = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom);
            run_op(rx, ry, rs, 1);
            check_rows($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_matrix_memory
`default_nettype wire

// File: doc/matrix_memory.md
MATRIX_MEMORY -- requirements
Module: matrix_memory

Interface
REQ-001 The block SHALL have parameter width_p, default 16, meaning playfield columns.
REQ-002 The block SHALL have parameter height_p, default 32, meaning playfield rows; row 0 is the top row.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 The block SHALL have port reset_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port mm_write_addr_i, input, point_t: block origin, with x as column and y as row.
REQ-006 The block SHALL have port mm_write_data_i, input, [3:0][3:0]: shape bitmap; bit [r][c] maps to cell (y+r, x+c).
REQ-007 The block SHALL have port mm_write_v_i, input, 1 bit: write request.
REQ-008 The block SHALL have port mm_is_ready_o, output, 1 bit: idle and able to accept a write.
REQ-009 The block SHALL have port rd_row_addr_i, input, $clog2(height_p) bits: read row select.
REQ-010 The block SHALL have port rd_row_data_o, output, width_p bits: registered row contents, one-cycle latency.
REQ-011 The block SHALL have port lines_v_o, output, 1 bit: one-cycle pulse marking the end of a write operation.
REQ-012 The block SHALL have port lines_o, output, 3 bits: rows cleared by the last operation, range 0..4.

Function
REQ-013 The block SHALL use the FSM states eIDLE, eMerge, eScan, eFill and eDone.
REQ-014 The block SHALL accept a write in eIDLE when mm_write_v_i=1; origin and shape are captured on that edge.
REQ-015 mm_is_ready_o SHALL be 1 only in eIDLE and SHALL be 0 in the cycle after acceptance.
REQ-016 mm_write_v_i SHALL be ignored in every state other than eIDLE.
REQ-017 eMerge SHALL last exactly 4 cycles; cycle r ORs shape row r into matrix row y+r.
REQ-018 Any cell with a column outside 0..width_p-1 or a row outside 0..height_p-1 SHALL be dropped, with no wrap-around.
REQ-019 Merging onto already occupied cells SHALL leave them occupied, as a plain OR.
REQ-020 eScan SHALL take height_p cycles and use a src pointer and a dst pointer, both starting at height_p-1.
REQ-021 In each eScan cycle, a full row (all ones) SHALL cause src to decrement and the cleared-row count to increment.
REQ-022 In each eScan cycle, a row that is not full SHALL be copied so that row[dst]=row[src], then both src and dst decrement.
REQ-023 eFill SHALL zero row dst and decrement dst once per cycle, for exactly count cycles; when count=0, eFill is skipped.
REQ-024 eDone SHALL last one cycle, assert lines_v_o=1, and hold lines_o=count.
REQ-025 The FSM SHALL return to eIDLE on the next edge after eDone.
REQ-026 Total latency SHALL be 4+height_p+count+1 cycles from acceptance to the lines_v_o pulse.
REQ-027 rd_row_data_o SHALL be valid only for reads issued in eIDLE; reads issued in other states return intermediate contents.
REQ-028 lines_o SHALL hold its value until the next eDone.

Reset
REQ-029 While reset_i=0, the FSM SHALL be in eIDLE, every matrix cell SHALL be 0, and count, src and dst SHALL be 0.
REQ-030 While reset_i=0, mm_is_ready_o SHALL be 0, rd_row_data_o SHALL be 0, lines_v_o SHALL be 0 and lines_o SHALL be 0.
REQ-031 mm_is_ready_o SHALL rise on the first clock edge after reset_i is deasserted.
REQ-032 Reset asserted mid-operation SHALL abort the operation immediately and clear the matrix, with no lines_v_o pulse.

Configuration
REQ-033 With macro MATRIX_LINE_CLEAR_EN defined, the block SHALL include eScan and eFill and behave as specified above.
REQ-034 Without MATRIX_LINE_CLEAR_EN, the FSM SHALL go from eMerge to eDone and lines_o SHALL be constant 0.
REQ-035 Without MATRIX_LINE_CLEAR_EN, latency SHALL be 5 cycles and eScan/eFill logic SHALL be absent.

Structure
REQ-036 point_t, a shape_t 4x4 typedef, the FSM state enum and the constant max_lines_c=4 SHALL live in package tetris.
REQ-037 The scan/fill compaction logic SHALL be a single sub-module, matrix_line_clear, instantiated only under MATRIX_LINE_CLEAR_EN.

Verification
REQ-038 Verification SHALL cover: reset, then origin (0,0) with shape row0=4'b0001 -> read of row 0 returns 16'h0001; lines_v_o pulses 4+32+0+1 cycles after acceptance with lines_o=0.
REQ-039 Verification SHALL cover: bottom row preset to 16'h7FFF, then origin (12,28) with shape row3=4'b1000 -> row 31 is cleared, row 31 receives the former row 30, lines_o=1 and row 0 reads 0.
REQ-040 Verification SHALL cover: rows 28..31 preset one cell short of full, then an I-piece completing all four -> lines_o=4 and rows 28..31 read 0.
REQ-041 Verification SHALL cover: origin (14,30) with a full 4x4 shape -> only columns 14..15 of rows 30..31 are set, with no wrap into columns 0..1 or row 0.
REQ-042 Verification SHALL cover: mm_write_v_i held high for 10 cycles -> exactly one write is accepted and mm_is_ready_o is 0 from the cycle after acceptance until eIDLE.
REQ-043 Verification SHALL cover: reset_i pulled low during eScan -> all rows read 0, there is no lines_v_o pulse, and mm_is_ready_o is 1 one cycle after release.
